// File: rtl/fifo_rx_apb_if.sv
// APB slave bus bundle for fifo_rx_apb.
//   psel/penable/pwrite/paddr/pwdata : requester -> completer
//   prdata/pready/pslverr            : completer -> requester
interface fifo_rx_apb_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/fifo_rx_apb.sv
// Serial receive deserializer feeding a DEPTH x WIDTH FIFO, drained over APB.
//   clk, reset_n          : clock, synchronous active-low reset
//   bit_valid, data_in    : serial bit strobe and bit from the CDR
//   frame_sync            : realigns the word boundary (drops the partial word)
//   apb                   : APB slave (DATA 0x0, STATUS 0x4, CTRL 0x8, CLR 0xC)
//   irq                   : registered level interrupt (threshold or overflow)
module fifo_rx_apb #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 64,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            bit_valid,
    input  logic            data_in,
    input  logic            frame_sync,
    fifo_rx_apb_if.slave    apb,
    output logic            irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             ovf;
    logic             irq_en;
    logic [PW-1:0]    thresh;

    logic [CW-1:0]    bit_pos;
    logic [CW-1:0]    bit_idx;
    logic [WIDTH-1:0] word_next;
    logic             word_done;

    logic [PW-1:0]    level;
    logic             empty;
    logic             full;

    logic             acc;
    logic             addr_ok;
    logic [1:0]       reg_sel;
    logic             pop;
    logic             flush;
    logic             ctrl_wr;
    logic             clr_ovf;
    logic             push_ok;
    logic             ovf_set;

    logic [31:0]      status_word;
    logic [31:0]      ctrl_word;
    logic             unused_pwdata;

    // Only a handful of write-data bits are architected.
    assign unused_pwdata = ^apb.pwdata;

    // Insert the incoming bit; frame_sync makes it bit 0 of a fresh word.
    always_comb begin : deser_c
        bit_pos   = frame_sync ? '0 : bit_cnt;
        bit_idx   = LSB_FIRST ? bit_pos : CW'(WIDTH - 1) - bit_pos;
        word_next = frame_sync ? '0 : shift_q;
        word_next[bit_idx] = data_in;
        word_done = bit_valid && (bit_pos == CW'(WIDTH - 1));
    end

    // FIFO occupancy from wrap-bit pointers.
    assign level = wr_ptr - rd_ptr;
    assign empty = (level == '0);
    assign full  = (level == PW'(DEPTH));

    // APB decode; reset masks the access so outputs read 0 while in reset.
    always_comb begin : decode_c
        acc     = reset_n && apb.psel && apb.penable;
        addr_ok = (apb.paddr[1:0] == 2'b00);
        reg_sel = apb.paddr[3:2];
        pop     = acc && !apb.pwrite && addr_ok && (reg_sel == 2'd0) && !empty;
        ctrl_wr = acc && apb.pwrite && addr_ok && (reg_sel == 2'd2);
        flush   = ctrl_wr && apb.pwdata[30];
        clr_ovf = acc && apb.pwrite && addr_ok && (reg_sel == 2'd3) && apb.pwdata[0];
        // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
        push_ok = word_done && !flush && (!full || pop);
        ovf_set = word_done && !flush && full && !pop;
    end

    assign status_word = {ovf, full, empty, 29'(level)};
    assign ctrl_word   = {irq_en, 1'b0, 30'(thresh)};
    assign apb.pready  = 1'b1;

    // Combinational read data and error response during the access phase.
    always_comb begin : rdata_c
        apb.prdata  = '0;
        apb.pslverr = 1'b0;
        if (acc) begin
            if (!addr_ok) begin
                apb.pslverr = 1'b1;
            end else begin
                case (reg_sel)
                    2'd0: begin
                        if (apb.pwrite || empty) apb.pslverr = 1'b1;
                        else apb.prdata = 32'(mem[rd_ptr[AW-1:0]]);
                    end
                    2'd1: begin
                        if (apb.pwrite) apb.pslverr = 1'b1;
                        else apb.prdata = status_word;
                    end
                    2'd2: begin
                        if (!apb.pwrite) apb.prdata = ctrl_word;
                    end
                    default: begin
                        if (!apb.pwrite) apb.pslverr = 1'b1;
                    end
                endcase
            end
        end
    end

    // Deserializer, pointers, control/status and interrupt registers.
    always_ff @(posedge clk) begin : state_q
        if (!reset_n) begin
            bit_cnt <= '0;
            shift_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ovf     <= 1'b0;
            irq_en  <= 1'b0;
            thresh  <= '0;
            irq     <= 1'b0;
        end else begin
            if (flush) begin
                bit_cnt <= '0;
                shift_q <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
            end else begin
                if (bit_valid) begin
                    if (word_done) begin
                        bit_cnt <= '0;
                        shift_q <= '0;
                    end else begin
                        bit_cnt <= bit_pos + CW'(1);
                        shift_q <= word_next;
                    end
                end else if (frame_sync) begin
                    bit_cnt <= '0;
                    shift_q <= '0;
                end
                if (push_ok) wr_ptr <= wr_ptr + PW'(1);
                if (pop)     rd_ptr <= rd_ptr + PW'(1);
            end
            if (ctrl_wr) begin
                irq_en <= apb.pwdata[31];
                thresh <= apb.pwdata[AW:0];
            end
            // A fresh overflow wins over a simultaneous clear.
            if (ovf_set)      ovf <= 1'b1;
            else if (clr_ovf) ovf <= 1'b0;
            irq <= irq_en && (((level >= thresh) && (thresh != '0)) || ovf);
        end
    end

    // Storage array, not reset.
    always_ff @(posedge clk) begin : mem_q
        if (push_ok) mem[wr_ptr[AW-1:0]] <= word_next;
    end

endmodule

// File: tb/tb_fifo_rx_apb.sv
// Self-checking bench for fifo_rx_apb: register table, directed corner cases,
// and a randomized run checked cycle-by-cycle against a queue-based model.
module tb_fifo_rx_apb;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned DEPTH     = 64;
    localparam int unsigned AW        = 6;
    localparam bit          LSB_FIRST = 1'b1;

    logic clk = 1'b0;
    logic reset_n;
    logic bit_valid;
    logic data_in;
    logic frame_sync;
    logic irq;

    fifo_rx_apb_if apb_if ();

    fifo_rx_apb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LSB_FIRST(LSB_FIRST)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bit_valid  (bit_valid),
        .data_in    (data_in),
        .frame_sync (frame_sync),
        .apb        (apb_if.slave),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state.
    logic [WIDTH-1:0] m_q [$];
    logic [WIDTH-1:0] m_pw;
    int               m_pcnt;
    logic             m_ovf;
    logic             m_irq_en;
    int               m_thresh;
    logic             m_irq;

    logic [31:0] last_prdata;
    logic        last_err;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_pw     = '0;
        m_pcnt   = 0;
        m_ovf    = 1'b0;
        m_irq_en = 1'b0;
        m_thresh = 0;
        m_irq    = 1'b0;
    endfunction

    // Expected APB response for the inputs currently applied.
    function automatic void model_outputs(output logic [31:0] e_rd, output logic e_err);
        int lvl = m_q.size();
        e_rd  = '0;
        e_err = 1'b0;
        if (reset_n && apb_if.psel && apb_if.penable) begin
            if (apb_if.paddr[1:0] != 2'b00) e_err = 1'b1;
            else if (apb_if.paddr == 4'h0) begin
                if (apb_if.pwrite || lvl == 0) e_err = 1'b1;
                else e_rd = 32'(m_q[0]);
            end else if (apb_if.paddr == 4'h4) begin
                if (apb_if.pwrite) e_err = 1'b1;
                else e_rd = {m_ovf, lvl == DEPTH, lvl == 0, 29'(lvl)};
            end else if (apb_if.paddr == 4'h8) begin
                if (!apb_if.pwrite) e_rd = {m_irq_en, 1'b0, 30'(m_thresh)};
            end else begin
                if (!apb_if.pwrite) e_err = 1'b1;
            end
        end
    endfunction

    // Advance the model across one rising edge.
    function automatic void model_advance();
        logic             acc, wr, rd, pop, flush, have_word, ovf_set;
        logic [WIDTH-1:0] word;
        int               lvl = m_q.size();
        if (!reset_n) begin
            model_reset();
            return;
        end
        acc   = apb_if.psel && apb_if.penable;
        wr    = acc && apb_if.pwrite;
        rd    = acc && !apb_if.pwrite;
        pop   = rd && apb_if.paddr == 4'h0 && lvl > 0;
        flush = wr && apb_if.paddr == 4'h8 && apb_if.pwdata[30];
        m_irq = m_irq_en && ((lvl >= m_thresh && m_thresh != 0) || m_ovf);

        have_word = 1'b0;
        ovf_set   = 1'b0;
        word      = '0;
        if (frame_sync) begin
            m_pw   = '0;
            m_pcnt = 0;
        end
        if (bit_valid) begin
            if (LSB_FIRST) m_pw[m_pcnt] = data_in;
            else m_pw[WIDTH-1-m_pcnt] = data_in;
            m_pcnt++;
            if (m_pcnt == WIDTH) begin
                word      = m_pw;
                have_word = 1'b1;
                m_pw      = '0;
                m_pcnt    = 0;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (flush) begin
            m_q.delete();
            m_pw   = '0;
            m_pcnt = 0;
        end else if (have_word) begin
            if (m_q.size() < DEPTH) m_q.push_back(word);
            else ovf_set = 1'b1;
        end
        if (wr && apb_if.paddr == 4'h8) begin
            m_irq_en = apb_if.pwdata[31];
            m_thresh = int'(apb_if.pwdata[AW:0]);
        end
        if (wr && apb_if.paddr == 4'hC && apb_if.pwdata[0]) m_ovf = 1'b0;
        if (ovf_set) m_ovf = 1'b1;
    endfunction

    // One clock: check outputs mid-cycle, then step the model across the edge.
    task automatic step();
        logic [31:0] e_rd;
        logic        e_err;
        @(negedge clk);
        model_outputs(e_rd, e_err);
        chk("pready", 32'(apb_if.pready), 32'd1);
        chk("prdata", apb_if.prdata, e_rd);
        chk("pslverr", 32'(apb_if.pslverr), 32'(e_err));
        chk("irq", 32'(irq), 32'(m_irq));
        last_prdata = apb_if.prdata;
        last_err    = apb_if.pslverr;
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_serial();
        bit_valid  = ($urandom % 3) != 0;
        data_in    = 1'($urandom);
        frame_sync = ($urandom % 40) == 0;
    endtask

    task automatic idle_serial();
        bit_valid  = 1'b0;
        data_in    = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        data_in   = b;
        step();
        idle_serial();
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++) send_bit(w[i]);
    endtask

    task automatic apb_xfer(input logic [3:0] addr, input logic wr, input logic [31:0] wdata,
                            input logic rnd, output logic [31:0] rdata, output logic err);
        apb_if.psel    = 1'b1;
        apb_if.penable = 1'b0;
        apb_if.pwrite  = wr;
        apb_if.paddr   = addr;
        apb_if.pwdata  = wdata;
        if (rnd) rand_serial();
        step();
        apb_if.penable = 1'b1;
        if (rnd) rand_serial();
        step();
        rdata = last_prdata;
        err   = last_err;
        apb_if.psel    = 1'b0;
        apb_if.penable = 1'b0;
        apb_if.pwrite  = 1'b0;
        if (rnd) idle_serial();
    endtask

    task automatic rd_chk(input string name, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_xfer(addr, 1'b0, 32'h0, 1'b0, d, e);
        chk(name, d, exp);
    endtask

    task automatic wr_reg(input logic [3:0] addr, input logic [31:0] wdata);
        logic [31:0] d;
        logic        e;
        apb_xfer(addr, 1'b1, wdata, 1'b0, d, e);
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [31:0] d;
        logic        e;

        tbl[0]  = '{4'h4, 1'b0, 32'h0,          32'h2000_0000, 1'b0};
        tbl[1]  = '{4'h8, 1'b0, 32'h0,          32'h0000_0000, 1'b0};
        tbl[2]  = '{4'h8, 1'b1, 32'h8000_0004,  32'h0000_0000, 1'b0};
        tbl[3]  = '{4'h8, 1'b0, 32'h0,          32'h8000_0004, 1'b0};
        tbl[4]  = '{4'h0, 1'b0, 32'h0,          32'h0000_0000, 1'b1};
        tbl[5]  = '{4'h4, 1'b0, 32'h0,          32'h2000_0000, 1'b0};
        tbl[6]  = '{4'h0, 1'b1, 32'h1234_5678,  32'h0000_0000, 1'b1};
        tbl[7]  = '{4'h4, 1'b1, 32'h1234_5678,  32'h0000_0000, 1'b1};
        tbl[8]  = '{4'hC, 1'b0, 32'h0,          32'h0000_0000, 1'b1};
        tbl[9]  = '{4'h2, 1'b0, 32'h0,          32'h0000_0000, 1'b1};
        tbl[10] = '{4'hC, 1'b1, 32'h0000_0001,  32'h0000_0000, 1'b0};
        tbl[11] = '{4'h8, 1'b1, 32'h0000_0000,  32'h0000_0000, 1'b0};

        model_reset();
        reset_n        = 1'b0;
        idle_serial();
        apb_if.psel    = 1'b0;
        apb_if.penable = 1'b0;
        apb_if.pwrite  = 1'b0;
        apb_if.paddr   = 4'h0;
        apb_if.pwdata  = 32'h0;

        // Reset: outputs quiet even with an access presented.
        step();
        apb_if.psel    = 1'b1;
        apb_if.penable = 1'b1;
        apb_if.paddr   = 4'h4;
        step();
        chk("rst_prdata", last_prdata, 32'h0);
        chk("rst_pslverr", 32'(last_err), 32'h0);
        apb_if.psel    = 1'b0;
        apb_if.penable = 1'b0;
        reset_n        = 1'b1;
        step();

        // Register map table.
        for (int i = 0; i < 12; i++) begin
            apb_xfer(tbl[i].addr, tbl[i].wr, tbl[i].wdata, 1'b0, d, e);
            chk($sformatf("tbl%0d_rd", i), d, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
        end

        // Basic word assembly: 1,0,1,0,0,0,0,1 -> 0x85.
        send_word(8'h85);
        rd_chk("b1_status_lvl1", 4'h4, 32'h0000_0001);
        rd_chk("b1_data", 4'h0, 32'h0000_0085);
        rd_chk("b1_status_lvl0", 4'h4, 32'h2000_0000);

        // frame_sync discards a partial word.
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        frame_sync = 1'b1;
        step();
        idle_serial();
        send_word(8'hFF);
        rd_chk("fs_status", 4'h4, 32'h0000_0001);
        rd_chk("fs_data", 4'h0, 32'h0000_00FF);

        // Threshold interrupt.
        wr_reg(4'h8, 32'h8000_0004);
        send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
        step();
        chk("irq_set", 32'(irq), 32'd1);
        rd_chk("irq_data", 4'h0, 32'h0000_0011);
        step();
        chk("irq_clr", 32'(irq), 32'd0);
        wr_reg(4'h8, 32'h4000_0000);
        rd_chk("irq_flush_status", 4'h4, 32'h2000_0000);

        // Overflow: DEPTH+1 words with no reads.
        for (int i = 0; i <= DEPTH; i++) send_word(8'(i + 1));
        rd_chk("ovf_status", 4'h4, 32'hC000_0040);
        rd_chk("ovf_first", 4'h0, 32'h0000_0001);
        wr_reg(4'hC, 32'h0000_0001);
        rd_chk("ovf_cleared", 4'h4, 32'h0000_003F);

        // Push completes in the same cycle as a DATA pop on a full FIFO.
        send_word(8'hAA);
        rd_chk("full_status", 4'h4, 32'h4000_0040);
        for (int i = 0; i < WIDTH - 1; i++) send_bit(1'b1);
        apb_if.psel   = 1'b1;
        apb_if.pwrite = 1'b0;
        apb_if.paddr  = 4'h0;
        step();
        apb_if.penable = 1'b1;
        bit_valid      = 1'b1;
        data_in        = 1'b1;
        step();
        chk("pp_data", last_prdata, 32'h0000_0002);
        idle_serial();
        apb_if.psel    = 1'b0;
        apb_if.penable = 1'b0;
        rd_chk("pp_status", 4'h4, 32'h4000_0040);
        wr_reg(4'h8, 32'h4000_0000);
        rd_chk("flush_status", 4'h4, 32'h2000_0000);

        // Reset mid-word drops the partial bits.
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        send_word(8'h5A);
        rd_chk("rstmid_data", 4'h0, 32'h0000_005A);
        rd_chk("rstmid_status", 4'h4, 32'h2000_0000);

        // Randomized traffic against the model.
        for (int it = 0; it < 3000; it++) begin
            int          k;
            int          rd_w;
            logic [31:0] w;
            rd_w = ((it / 400) % 2 == 0) ? 2 : 7;
            if (($urandom % 10) < 6) begin
                rand_serial();
                step();
                idle_serial();
            end else begin
                k = int'($urandom % 16);
                w = $urandom;
                if (k < rd_w) begin
                    apb_xfer(4'h0, 1'b0, w, 1'b1, d, e);
                end else if (k < 9) begin
                    apb_xfer(4'h4, 1'b0, w, 1'b1, d, e);
                end else if (k == 9) begin
                    apb_xfer(4'h8, 1'b0, w, 1'b1, d, e);
                end else if (k == 10) begin
                    w[30]   = (($urandom % 8) == 0);
                    w[AW:0] = 7'($urandom % (DEPTH + 1));
                    apb_xfer(4'h8, 1'b1, w, 1'b1, d, e);
                end else if (k == 11) begin
                    apb_xfer(4'hC, 1'b1, w, 1'b1, d, e);
                end else if (k < 15) begin
                    if (4'(w) == 4'h8) w[30] = 1'b0;
                    apb_xfer(4'(w), 1'($urandom), w, 1'b1, d, e);
                end else begin
                    apb_if.psel   = 1'b1;
                    apb_if.pwrite = 1'b0;
                    apb_if.paddr  = 4'h0;
                    rand_serial();
                    step();
                    apb_if.penable = 1'b1;
                    reset_n        = ($urandom % 4) == 0 ? 1'b1 : 1'b0;
                    rand_serial();
                    step();
                    reset_n        = 1'b1;
                    apb_if.psel    = 1'b0;
                    apb_if.penable = 1'b0;
                    idle_serial();
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
